// File: rtl/pe_au_sequencer.sv
// Operand/opmode sequencer for one PE's DSP48E2 arithmetic unit in a FIOS
// Montgomery pass: S multiply-accumulates followed by one carry flush.
// Every op is described by a {valid, last, idx, op} descriptor that travels
// down one delay line; taps on that line pre-skew B, C/CEC, OPMODE and the
// result strobe to match the DSP's internal register levels.
//
// state | meaning
// IDLE  | ready for a pass; A is captured on start
// READ  | one word-memory read per cycle, j = 0..S-1
// FLUSH | one cycle, pushes the P>>17 carry-flush op
// DRAIN | waits for the flush result, then back to IDLE
module pe_au_sequencer #(
  parameter int ABREG  = 1,
  parameter int MREG   = 1,
  parameter int CREG   = 1,
  parameter int S      = 8,
  parameter int RD_LAT = 1,
  localparam int AW    = (S > 1) ? $clog2(S) : 1,
  localparam int IW    = $clog2(S + 1)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [16:0]   a_i,
  output logic          ready_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [16:0]   b_i,
  input  logic [16:0]   t_i,
  output logic [16:0]   A_o,
  output logic [16:0]   B_o,
  output logic [33:0]   C_o,
  output logic          CREG_en_o,
  output logic [8:0]    OPMODE_o,
  input  logic [33:0]   P_i,
  output logic          res_valid_o,
  output logic [IW-1:0] res_idx_o,
  output logic [33:0]   res_o,
  output logic          done_o
);

  localparam int L       = 1 + ABREG + MREG;
  localparam int DL      = RD_LAT + L;
  // C leads the ALU cycle by CREG, OPMODE always by one (OPMODEREG=1).
  localparam int D_C     = ABREG + MREG - CREG;
  localparam int TAP_ISS = RD_LAT;
  localparam int TAP_C   = RD_LAT + D_C;
  localparam int TAP_OP  = RD_LAT + ABREG + MREG - 1;
  localparam int TAP_RET = DL;

  localparam logic [8:0] OP_FIRST = 9'h035;  // M + C
  localparam logic [8:0] OP_ACC   = 9'h1E5;  // M + C + P>>17
  localparam logic [8:0] OP_FLUSH = 9'h060;  // P>>17

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DRAIN} state_t;

  typedef struct packed {
    logic          v;
    logic          last;
    logic [IW-1:0] idx;
    logic [8:0]    op;
  } desc_t;

  state_t        state, state_nxt;
  logic [AW-1:0] j_q, j_nxt;
  logic [16:0]   a_q;
  logic          capture;
  desc_t         desc_in;
  desc_t         dl [1:DL];
  logic [16:0]   t_c;

  // State, word counter and captured multiplier word.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= IDLE;
      j_q   <= '0;
      a_q   <= '0;
    end else begin
      state <= state_nxt;
      j_q   <= j_nxt;
      if (capture) a_q <= a_i;
    end
  end

  // Next-state, read strobe and descriptor generation.
  always_comb begin
    state_nxt = state;
    j_nxt     = j_q;
    capture   = 1'b0;
    ready_o   = 1'b0;
    rd_en_o   = 1'b0;
    desc_in   = '0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          capture   = 1'b1;
          j_nxt     = '0;
          state_nxt = READ;
        end
      end
      READ: begin
        rd_en_o     = 1'b1;
        desc_in.v   = 1'b1;
        desc_in.idx = IW'(j_q);
        desc_in.op  = (j_q == '0) ? OP_FIRST : OP_ACC;
        if (j_q == AW'(S - 1)) state_nxt = FLUSH;
        else                   j_nxt     = j_q + AW'(1);
      end
      FLUSH: begin
        desc_in.v    = 1'b1;
        desc_in.last = 1'b1;
        desc_in.idx  = IW'(S);
        desc_in.op   = OP_FLUSH;
        state_nxt    = DRAIN;
      end
      DRAIN: begin
        if (dl[TAP_RET].v && dl[TAP_RET].last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Descriptor delay line: stage n holds the descriptor pushed n cycles ago.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int n = 1; n <= DL; n++) dl[n] <= '0;
    end else begin
      dl[1] <= desc_in;
      for (int n = 2; n <= DL; n++) dl[n] <= dl[n-1];
    end
  end

  generate
    if (D_C == 0) begin : g_tc_direct
      assign t_c = t_i;
    end else begin : g_tc_delay
      logic [16:0] tq [1:D_C];
      // Holds t_j until the C port's issue slot.
      always_ff @(posedge clock_i) begin
        if (reset_i) begin
          for (int n = 1; n <= D_C; n++) tq[n] <= '0;
        end else begin
          tq[1] <= t_i;
          for (int n = 2; n <= D_C; n++) tq[n] <= tq[n-1];
        end
      end
      assign t_c = tq[D_C];
    end
  endgenerate

  assign rd_addr_o   = rd_en_o ? j_q : '0;
  assign A_o         = a_q;
  assign B_o         = (dl[TAP_ISS].v && !dl[TAP_ISS].last) ? b_i : '0;
  assign CREG_en_o   = dl[TAP_C].v && !dl[TAP_C].last;
  assign C_o         = CREG_en_o ? {17'b0, t_c} : '0;
  assign OPMODE_o    = dl[TAP_OP].v ? dl[TAP_OP].op : 9'h000;
  assign res_valid_o = dl[TAP_RET].v;
  assign res_idx_o   = dl[TAP_RET].idx;
  assign res_o       = dl[TAP_RET].v ? P_i : '0;
  assign done_o      = dl[TAP_RET].v && dl[TAP_RET].last;

endmodule

// File: tb/tb_pe_au_sequencer.sv
// Bench for pe_au_sequencer: ten instances (defaults, S=2, six DSP register
// combinations, RD_LAT=3, S=1) each with a word memory and a DSP48E2 model.
module tb_pe_au_sequencer;

  localparam int NI = 10;
  localparam int C_AB [NI] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
  localparam int C_MR [NI] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
  localparam int C_CR [NI] = '{1, 1, 0, 1, 0, 1, 0, 1, 1, 1};
  localparam int C_S  [NI] = '{8, 2, 3, 3, 3, 3, 3, 3, 8, 1};
  localparam int C_R  [NI] = '{1, 1, 1, 1, 1, 1, 1, 1, 3, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_w   [NI];
  logic        start_w [NI];
  logic [16:0] a_w     [NI];
  logic        ready_w [NI], rd_en_w [NI], creg_w [NI], valid_w [NI], done_w [NI];
  logic [7:0]  addr_w  [NI], idx_w [NI];
  logic [16:0] A_w     [NI], B_w [NI];
  logic [33:0] C_w     [NI], res_w [NI];
  logic [8:0]  op_w    [NI];
  logic [16:0] mem_b   [NI][8];
  logic [16:0] mem_t   [NI][8];

  logic [16:0] sw_b [3] = '{17'h1FFFF, 17'h12345, 17'h0F0F0};
  logic [16:0] sw_t [3] = '{17'h1FFFF, 17'h00001, 17'h15555};

  int n_chk = 0;
  int n_err = 0;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_inst
      localparam int AW = (C_S[gi] > 1) ? $clog2(C_S[gi]) : 1;
      localparam int IW = $clog2(C_S[gi] + 1);
      logic [AW-1:0] addr;
      logic [IW-1:0] idx;
      logic [16:0]   b_i, t_i;
      logic [AW-1:0] ap [1:3];
      logic [16:0]   a_r, b_r, aq, bq;
      logic [33:0]   m, m_r, mq, c_r, cq, p_r;
      logic [8:0]    op_r;

      pe_au_sequencer #(
        .ABREG(C_AB[gi]), .MREG(C_MR[gi]), .CREG(C_CR[gi]),
        .S(C_S[gi]), .RD_LAT(C_R[gi])
      ) u_dut (
        .clock_i(clk), .reset_i(rst_w[gi]), .start_i(start_w[gi]), .a_i(a_w[gi]),
        .ready_o(ready_w[gi]), .rd_en_o(rd_en_w[gi]), .rd_addr_o(addr),
        .b_i(b_i), .t_i(t_i), .A_o(A_w[gi]), .B_o(B_w[gi]), .C_o(C_w[gi]),
        .CREG_en_o(creg_w[gi]), .OPMODE_o(op_w[gi]), .P_i(p_r),
        .res_valid_o(valid_w[gi]), .res_idx_o(idx), .res_o(res_w[gi]),
        .done_o(done_w[gi])
      );

      assign addr_w[gi] = 8'(addr);
      assign idx_w[gi]  = 8'(idx);

      // Word memory with RD_LAT cycles of read latency.
      always @(posedge clk) begin
        ap[1] <= addr;
        ap[2] <= ap[1];
        ap[3] <= ap[2];
      end
      assign b_i = mem_b[gi][int'(ap[C_R[gi]])];
      assign t_i = mem_t[gi][int'(ap[C_R[gi]])];

      // DSP48E2 model: AB/M/C register levels, OPMODEREG=1, PREG=1.
      always @(posedge clk) begin
        a_r  <= A_w[gi];
        b_r  <= B_w[gi];
        m_r  <= m;
        op_r <= op_w[gi];
        if (creg_w[gi]) c_r <= C_w[gi];
        case (op_r)
          9'h035:  p_r <= mq + cq;
          9'h1E5:  p_r <= mq + cq + (p_r >> 17);
          9'h060:  p_r <= p_r >> 17;
          default: p_r <= '0;
        endcase
      end
      assign aq = (C_AB[gi] != 0) ? a_r : A_w[gi];
      assign bq = (C_AB[gi] != 0) ? b_r : B_w[gi];
      assign m  = 34'(aq) * 34'(bq);
      assign mq = (C_MR[gi] != 0) ? m_r : m;
      assign cq = (C_CR[gi] != 0) ? c_r : C_w[gi];
    end
  endgenerate

  // Per-pass recorder; cycle numbers are relative to the start-accept cycle.
  int          cyc = 0;
  int          rel [NI] = '{default: 0};
  int          n_res [NI] = '{default: 0};
  int          n_acc [NI] = '{default: 0};
  int          vtot [NI] = '{default: 0};
  int          both [NI] = '{default: 0};
  int          first_op [NI] = '{default: -1};
  int          first_cen [NI] = '{default: -1};
  int          done_rel [NI] = '{default: -1};
  int          rdy_rel [NI] = '{default: -1};
  int          res_rel [NI][9];
  logic [33:0] res_val [NI][9];
  int          acc_log [NI][8];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < NI; g++) begin
      if (start_w[g] && ready_w[g]) begin
        rel[g]       <= 0;
        n_res[g]     <= 0;
        first_op[g]  <= -1;
        first_cen[g] <= -1;
        done_rel[g]  <= -1;
        rdy_rel[g]   <= -1;
        if (n_acc[g] < 8) acc_log[g][n_acc[g]] <= cyc;
        n_acc[g] <= n_acc[g] + 1;
      end else begin
        rel[g] <= rel[g] + 1;
        if (ready_w[g] && rdy_rel[g] < 0) rdy_rel[g] <= rel[g] + 1;
        if (op_w[g] != 9'h000 && first_op[g] < 0) first_op[g] <= rel[g] + 1;
        if (creg_w[g] && first_cen[g] < 0) first_cen[g] <= rel[g] + 1;
        if (done_w[g]) done_rel[g] <= rel[g] + 1;
        if (valid_w[g] && idx_w[g] < 8'd9) begin
          n_res[g]                    <= n_res[g] + 1;
          res_rel[g][int'(idx_w[g])]  <= rel[g] + 1;
          res_val[g][int'(idx_w[g])]  <= res_w[g];
        end
      end
      if (valid_w[g]) vtot[g] <= vtot[g] + 1;
      if (done_w[g] && ready_w[g]) both[g] <= both[g] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] pv;
    int          l, vt0;

    for (int g = 0; g < NI; g++) begin
      rst_w[g]   = 1'b1;
      start_w[g] = 1'b0;
      a_w[g]     = '0;
      for (int j = 0; j < 8; j++) begin
        mem_b[g][j] = '0;
        mem_t[g][j] = '0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) rst_w[g] = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    chk("rst_ready",   64'(ready_w[0]), 64'd1);
    chk("rst_rd_en",   64'(rd_en_w[0]), 64'd0);
    chk("rst_rd_addr", 64'(addr_w[0]),  64'd0);
    chk("rst_valid",   64'(valid_w[0]), 64'd0);
    chk("rst_idx",     64'(idx_w[0]),   64'd0);
    chk("rst_res",     64'(res_w[0]),   64'd0);
    chk("rst_done",    64'(done_w[0]),  64'd0);
    chk("rst_A",       64'(A_w[0]),     64'd0);
    chk("rst_B",       64'(B_w[0]),     64'd0);
    chk("rst_C",       64'(C_w[0]),     64'd0);
    chk("rst_creg_en", 64'(creg_w[0]),  64'd0);
    chk("rst_opmode",  64'(op_w[0]),    64'd0);
    chk("rst_B_ab0",   64'(B_w[2]),     64'd0);

    // Load pass data for instances 0..8.
    for (int j = 0; j < 8; j++) begin
      mem_b[0][j] = 17'(j + 1);
      mem_b[8][j] = 17'(j + 1);
    end
    a_w[0] = 17'd1;
    a_w[8] = 17'd1;
    for (int j = 0; j < 2; j++) begin
      mem_b[1][j] = 17'h1FFFF;
      mem_t[1][j] = 17'h1FFFF;
    end
    a_w[1] = 17'h1FFFF;
    for (int g = 2; g < 8; g++) begin
      a_w[g] = 17'h1ABCD;
      for (int j = 0; j < 3; j++) begin
        mem_b[g][j] = sw_b[j];
        mem_t[g][j] = sw_t[j];
      end
    end

    for (int g = 0; g < 9; g++) start_w[g] = 1'b1;
    @(posedge clk);
    #1;
    for (int g = 0; g < 9; g++) start_w[g] = 1'b0;
    chk("A_captured", 64'(A_w[1]), 64'h1FFFF);
    repeat (20) @(posedge clk);
    #1;

    // Defaults and RD_LAT=3: result j = j+1, flush result 0.
    for (int g = 0; g < 9; g += 8) begin
      for (int j = 0; j < 8; j++) begin
        chk($sformatf("g%0d_res%0d_val", g, j), 64'(res_val[g][j]), 64'(j + 1));
        chk($sformatf("g%0d_res%0d_cyc", g, j), 64'(res_rel[g][j]), 64'(1 + j + C_R[g] + 3));
      end
      chk($sformatf("g%0d_res8_val", g), 64'(res_val[g][8]), 64'd0);
      chk($sformatf("g%0d_res8_cyc", g), 64'(res_rel[g][8]), 64'(9 + C_R[g] + 3));
      chk($sformatf("g%0d_done_cyc", g), 64'(done_rel[g]),   64'(9 + C_R[g] + 3));
      chk($sformatf("g%0d_ready_cyc", g), 64'(rdy_rel[g]),   64'(10 + C_R[g] + 3));
      chk($sformatf("g%0d_n_res", g),    64'(n_res[g]),      64'd9);
      chk($sformatf("g%0d_done_ready", g), 64'(both[g]),     64'd0);
    end

    // S=2 with all-ones operands.
    chk("s2_res0", 64'(res_val[1][0]), 64'h3FFFE0000);
    chk("s2_res1", 64'(res_val[1][1]), 64'h3FFFFFFFF);
    chk("s2_res2", 64'(res_val[1][2]), 64'h1FFFF);
    chk("s2_res2_cyc", 64'(res_rel[1][2]), 64'd7);
    chk("s2_done_cyc", 64'(done_rel[1]),   64'd7);

    // Register-level sweep.
    for (int g = 2; g < 8; g++) begin
      l  = 1 + C_AB[g] + C_MR[g];
      pv = '0;
      for (int j = 0; j < 3; j++) begin
        pv = 64'(a_w[g]) * 64'(sw_b[j]) + 64'(sw_t[j]) + ((j == 0) ? 64'd0 : (pv >> 17));
        chk($sformatf("sw%0d_res%0d_val", g, j), 64'(res_val[g][j]), pv);
        chk($sformatf("sw%0d_res%0d_cyc", g, j), 64'(res_rel[g][j]), 64'(2 + j + l));
      end
      pv = pv >> 17;
      chk($sformatf("sw%0d_res3_val", g), 64'(res_val[g][3]), pv);
      chk($sformatf("sw%0d_done_cyc", g), 64'(done_rel[g]),   64'(5 + l));
      chk($sformatf("sw%0d_opmode_cyc", g), 64'(first_op[g]), 64'(1 + C_AB[g] + C_MR[g]));
      chk($sformatf("sw%0d_creg_en_cyc", g), 64'(first_cen[g]), 64'(2 + C_AB[g] + C_MR[g] - C_CR[g]));
      chk($sformatf("sw%0d_n_res", g), 64'(n_res[g]), 64'd4);
    end

    // S=1 with start held high: accepts every 7 cycles.
    mem_b[9][0] = 17'd5;
    mem_t[9][0] = 17'd3;
    a_w[9]      = 17'd7;
    start_w[9]  = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    start_w[9] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("held_n_acc",  64'(n_acc[9]), 64'd3);
    chk("held_gap01",  64'(acc_log[9][1] - acc_log[9][0]), 64'd7);
    chk("held_gap12",  64'(acc_log[9][2] - acc_log[9][1]), 64'd7);
    chk("held_res0",   64'(res_val[9][0]), 64'h26);
    chk("held_res1",   64'(res_val[9][1]), 64'h0);
    chk("held_res0_cyc", 64'(res_rel[9][0]), 64'd5);
    chk("held_done_cyc", 64'(done_rel[9]),   64'd6);
    chk("held_ready_cyc", 64'(rdy_rel[9]),   64'd7);
    chk("held_n_valid", 64'(vtot[9]), 64'd6);
    chk("held_done_ready", 64'(both[9]), 64'd0);

    // Reset in the cycle of read j=3, then a clean pass.
    for (int j = 0; j < 8; j++) begin
      mem_b[0][j] = 17'(3 * j + 2);
      mem_t[0][j] = 17'(j);
    end
    a_w[0]     = 17'd2;
    start_w[0] = 1'b1;
    @(posedge clk);
    #1;
    start_w[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rd_en",   64'(rd_en_w[0]), 64'd1);
    chk("mid_rd_addr", 64'(addr_w[0]),  64'd3);
    rst_w[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_w[0] = 1'b0;
    vt0 = vtot[0];
    chk("post_rst_ready",   64'(ready_w[0]), 64'd1);
    chk("post_rst_rd_en",   64'(rd_en_w[0]), 64'd0);
    chk("post_rst_valid",   64'(valid_w[0]), 64'd0);
    chk("post_rst_done",    64'(done_w[0]),  64'd0);
    chk("post_rst_opmode",  64'(op_w[0]),    64'd0);
    chk("post_rst_creg_en", 64'(creg_w[0]),  64'd0);
    repeat (2) @(posedge clk);
    #1;
    start_w[0] = 1'b1;
    @(posedge clk);
    #1;
    start_w[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("rerun_res%0d_val", j), 64'(res_val[0][j]), 64'(7 * j + 4));
      chk($sformatf("rerun_res%0d_cyc", j), 64'(res_rel[0][j]), 64'(5 + j));
    end
    chk("rerun_res8_val", 64'(res_val[0][8]), 64'd0);
    chk("rerun_n_valid",  64'(vtot[0] - vt0), 64'd9);
    chk("rerun_n_res",    64'(n_res[0]), 64'd9);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
